// File: rtl/conv_pkg.sv
// Shared definitions for the convolution operand path: loader states and matrix geometry.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int unsigned A_ELEMS        = 16;
  localparam int unsigned B_ELEMS        = 9;
  localparam int unsigned FRAME_ELEMS    = A_ELEMS + B_ELEMS;
  localparam int unsigned DEFAULT_DATA_W = 8;

endpackage

// File: rtl/operand_loader.sv
// Byte-stream front end for the convolution top: assembles A (4x4) and B (3x3), commits, drives run.
// Build option: OPERAND_LOADER_CHECKSUM_EN adds a trailing checksum byte, CHECK state and live error.
module operand_loader
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned RUN_HOLD = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [A_ELEMS*DATA_W-1:0]   a_mat,
  output logic [B_ELEMS*DATA_W-1:0]   b_mat,
  output logic                        run,
  output logic                        frame_done,
  output logic                        error
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_ELEMS - 1);
`ifdef OPERAND_LOADER_CHECKSUM_EN
  localparam int unsigned SH_ELEMS = FRAME_ELEMS;
`else
  // Last data byte goes straight from in_data into the commit, so it needs no shadow slot.
  localparam int unsigned SH_ELEMS = FRAME_ELEMS - 1;
`endif

  state_t                          state, state_nx;
  logic [4:0]                      index;
  logic [15:0]                     hold_cnt;
  logic [SH_ELEMS*DATA_W-1:0]      shadow;
  logic [FRAME_ELEMS*DATA_W-1:0]   frame;
  logic                            xfer, last, commit, store;

  assign in_ready   = !reset && (state != RUN);
  assign xfer       = in_valid && in_ready;
  assign last       = (index == LAST_IDX);
  assign run        = (state == RUN);
  assign frame_done = (state == RUN) && (hold_cnt == 16'd1);

`ifdef OPERAND_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              chk_fail;

  assign store = xfer && (state == IDLE || state == LOAD);
  assign frame = shadow;
`else
  assign store = xfer && (state == IDLE || state == LOAD) && !last;
  assign frame = {in_data, shadow};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
`ifdef OPERAND_LOADER_CHECKSUM_EN
    chk_fail = 1'b0;
`endif
    case (state)
      IDLE: if (xfer) state_nx = LOAD;
      LOAD: if (xfer && last) begin
`ifdef OPERAND_LOADER_CHECKSUM_EN
        state_nx = CHECK;
`else
        state_nx = RUN;
        commit   = 1'b1;
`endif
      end
`ifdef OPERAND_LOADER_CHECKSUM_EN
      CHECK: if (xfer) begin
        if (in_data == sum) begin
          state_nx = RUN;
          commit   = 1'b1;
        end else begin
          state_nx = IDLE;
          chk_fail = 1'b1;
        end
      end
`endif
      RUN: if (hold_cnt == 16'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index    <= '0;
      shadow   <= '0;
      a_mat    <= '0;
      b_mat    <= '0;
      hold_cnt <= '0;
    end else begin
      if (store) shadow[DATA_W*index +: DATA_W] <= in_data;
      if (xfer) begin
        if (state == IDLE)      index <= 5'd1;
        else if (state == LOAD) index <= last ? '0 : index + 5'd1;
      end
      if (commit) begin
        a_mat    <= frame[A_ELEMS*DATA_W-1:0];
        b_mat    <= frame[FRAME_ELEMS*DATA_W-1:A_ELEMS*DATA_W];
        hold_cnt <= 16'(RUN_HOLD);
      end else if (state == RUN) begin
        hold_cnt <= hold_cnt - 16'd1;
      end
    end
  end

`ifdef OPERAND_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum   <= '0;
      error <= 1'b0;
    end else begin
      if (xfer) begin
        case (state)
          IDLE:    sum <= in_data;
          LOAD:    sum <= sum + in_data;
          default: sum <= '0;
        endcase
      end
      if (xfer && state == IDLE) error <= 1'b0;
      else if (chk_fail)         error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
